// File: rtl/instruction_fetch.sv
// instruction_fetch: program counter and instruction register stage feeding
// a combinational program ROM. Steps the PC, registers the returned word with
// a valid flag, honours stall and branch/jump redirects from execute, and
// keeps a saturating count of delivered instructions for debug.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC = 16'd0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iEnable,
  input  logic        iStall,
  input  logic        iRedirect,
  input  logic [15:0] iTarget,
  input  logic [27:0] iInstruction,
  output logic [15:0] oAddress,
  output logic [27:0] oInstruction,
  output logic [15:0] oInstrAddress,
  output logic        oValid,
  output logic [15:0] oFetchCount
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state, state_nxt;

  logic [15:0] pc, pc_nxt;
  logic [27:0] ir, ir_nxt;
  logic [15:0] ir_addr, ir_addr_nxt;
  logic        valid, valid_nxt;
  logic [15:0] count, count_nxt;

  // A word is delivered only on a normal fetch edge; stall, redirect and
  // disable all leave the instruction register untouched.
  logic        fetch_fire;
  logic        count_full;

  assign count_full = (count == '1);

  // FSM state register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-datapath decode; priority redirect > disable > stall > fetch.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_nxt      = ir;
    ir_addr_nxt = ir_addr;
    valid_nxt   = valid;
    fetch_fire  = 1'b0;

    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (iRedirect) begin
          // A redirect while parked only retargets the PC; the state holds.
          pc_nxt = iTarget;
        end else if (iEnable) begin
          state_nxt = RUN;
        end
      end

      RUN: begin
        if (iRedirect) begin
          // The word at the old PC is dropped; stall is ignored on this edge.
          pc_nxt    = iTarget;
          valid_nxt = 1'b0;
        end else if (!iEnable) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end else if (!iStall) begin
          fetch_fire  = 1'b1;
          ir_nxt      = iInstruction;
          ir_addr_nxt = pc;
          valid_nxt   = 1'b1;
          pc_nxt      = pc + 16'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // Saturating delivered-instruction counter decode.
  always_comb begin
    count_nxt = count;
    if (fetch_fire && !count_full) begin
      count_nxt = count + 16'd1;
    end
  end

  // Datapath registers: PC, instruction register, valid flag and counter.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      ir_addr <= '0;
      valid   <= 1'b0;
      count   <= '0;
    end else begin
      pc      <= pc_nxt;
      ir      <= ir_nxt;
      ir_addr <= ir_addr_nxt;
      valid   <= valid_nxt;
      count   <= count_nxt;
    end
  end

  assign oAddress      = pc;
  assign oInstruction  = ir;
  assign oInstrAddress = ir_addr;
  assign oValid        = valid;
  assign oFetchCount   = count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: a ROM model returns {address,12'h0};
// expected delivered addresses are queued as stimulus is driven and popped
// as the DUT delivers words.
module tb_instruction_fetch;

  logic        Clock;
  logic        Reset;
  logic        iEnable;
  logic        iStall;
  logic        iRedirect;
  logic [15:0] iTarget;
  logic [27:0] iInstruction;
  logic [15:0] oAddress;
  logic [27:0] oInstruction;
  logic [15:0] oInstrAddress;
  logic        oValid;
  logic [15:0] oFetchCount;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [15:0] exp_q[$];

  instruction_fetch #(.RESET_PC(16'd0)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iEnable      (iEnable),
    .iStall       (iStall),
    .iRedirect    (iRedirect),
    .iTarget      (iTarget),
    .iInstruction (iInstruction),
    .oAddress     (oAddress),
    .oInstruction (oInstruction),
    .oInstrAddress(oInstrAddress),
    .oValid       (oValid),
    .oFetchCount  (oFetchCount)
  );

  // Combinational ROM model.
  assign iInstruction = {oAddress, 12'h000};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Advance one edge and expect the next queued address to be delivered.
  task automatic step_deliver(input string tag);
    logic [15:0] a;
    step();
    if (exp_q.size() == 0) begin
      check({tag, " queue_empty"}, 32'd1, 32'd0);
    end else begin
      a = exp_q.pop_front();
      check({tag, " valid"}, {31'd0, oValid}, 32'd1);
      check({tag, " addr"}, {16'd0, oInstrAddress}, {16'd0, a});
      check({tag, " instr"}, {4'd0, oInstruction}, {4'd0, a, 12'h000});
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    Reset     = 1'b1;
    iEnable   = 1'b0;
    iStall    = 1'b0;
    iRedirect = 1'b0;
    iTarget   = '0;

    step();
    step();
    check("rst addr",   {16'd0, oAddress}, 32'd0);
    check("rst valid",  {31'd0, oValid}, 32'd0);
    check("rst count",  {16'd0, oFetchCount}, 32'd0);
    check("rst instr",  {4'd0, oInstruction}, 32'd0);
    check("rst iaddr",  {16'd0, oInstrAddress}, 32'd0);

    // Release and enable: IDLE->RUN on edge 1, first word on edge 2.
    Reset   = 1'b0;
    iEnable = 1'b1;
    for (int unsigned i = 0; i < 6; i++) exp_q.push_back(16'(i));
    step();
    check("edge1 valid", {31'd0, oValid}, 32'd0);
    check("edge1 addr",  {16'd0, oAddress}, 32'd0);
    for (int unsigned i = 0; i < 4; i++) step_deliver("seq");
    check("count4", {16'd0, oFetchCount}, 32'd4);
    step_deliver("seq");
    step_deliver("seq");

    // Stall for 3 cycles while oInstrAddress=5.
    iStall = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check("stall valid", {31'd0, oValid}, 32'd1);
      check("stall iaddr", {16'd0, oInstrAddress}, 32'd5);
      check("stall instr", {4'd0, oInstruction}, {4'd0, 16'd5, 12'h000});
      check("stall addr",  {16'd0, oAddress}, 32'd6);
      check("stall count", {16'd0, oFetchCount}, 32'd6);
    end
    iStall = 1'b0;
    for (int unsigned i = 6; i < 15; i++) exp_q.push_back(16'(i));
    for (int unsigned i = 6; i < 15; i++) step_deliver("post_stall");
    check("pre_redir addr", {16'd0, oAddress}, 32'd15);

    // Redirect to 2 while oAddress=15: one bubble, 15 never delivered.
    iRedirect = 1'b1;
    iTarget   = 16'd2;
    step();
    check("redir bubble", {31'd0, oValid}, 32'd0);
    check("redir pc",     {16'd0, oAddress}, 32'd2);
    check("redir iaddr",  {16'd0, oInstrAddress}, 32'd14);
    iRedirect = 1'b0;
    exp_q.push_back(16'd2);
    exp_q.push_back(16'd3);
    step_deliver("redir");
    step_deliver("redir");
    check("count17", {16'd0, oFetchCount}, 32'd17);

    // Redirect together with stall: the redirect wins.
    iRedirect = 1'b1;
    iStall    = 1'b1;
    iTarget   = 16'd8;
    step();
    check("rs bubble", {31'd0, oValid}, 32'd0);
    check("rs pc",     {16'd0, oAddress}, 32'd8);
    iRedirect = 1'b0;
    iStall    = 1'b0;
    exp_q.push_back(16'd8);
    step_deliver("redir_stall");

    // Wrap-around across 16'hFFFF.
    iRedirect = 1'b1;
    iTarget   = 16'hFFFE;
    step();
    check("wrap bubble", {31'd0, oValid}, 32'd0);
    iRedirect = 1'b0;
    exp_q.push_back(16'hFFFE);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    step_deliver("wrap");
    step_deliver("wrap");
    step_deliver("wrap");
    check("wrap pc",  {16'd0, oAddress}, 32'd1);
    check("count21",  {16'd0, oFetchCount}, 32'd21);

    // Disable: back to IDLE, PC and IR hold.
    iEnable = 1'b0;
    step();
    check("dis valid", {31'd0, oValid}, 32'd0);
    check("dis pc",    {16'd0, oAddress}, 32'd1);
    check("dis iaddr", {16'd0, oInstrAddress}, 32'd0);
    step();
    check("idle valid", {31'd0, oValid}, 32'd0);
    check("idle pc",    {16'd0, oAddress}, 32'd1);

    // Redirect while parked retargets the PC only.
    iRedirect = 1'b1;
    iTarget   = 16'h0030;
    step();
    check("idle redir pc",    {16'd0, oAddress}, 32'h30);
    check("idle redir valid", {31'd0, oValid}, 32'd0);
    iRedirect = 1'b0;
    iEnable   = 1'b1;
    step();
    check("reen edge1 valid", {31'd0, oValid}, 32'd0);
    exp_q.push_back(16'h0030);
    step_deliver("reenable");
    check("count22", {16'd0, oFetchCount}, 32'd22);

    // Asynchronous reset between edges.
    #2;
    check("pre_rst valid", {31'd0, oValid}, 32'd1);
    Reset = 1'b1;
    #1;
    check("async valid", {31'd0, oValid}, 32'd0);
    check("async count", {16'd0, oFetchCount}, 32'd0);
    check("async pc",    {16'd0, oAddress}, 32'd0);
    check("async instr", {4'd0, oInstruction}, 32'd0);
    iEnable = 1'b0;
    step();
    Reset = 1'b0;
    step();
    step();
    check("post_rst valid", {31'd0, oValid}, 32'd0);
    check("post_rst pc",    {16'd0, oAddress}, 32'd0);
    check("queue drained",  exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
